// File: rtl/led_frame_refresh.sv
// led_frame_refresh: double-buffered column display refresher that streams a command byte and NUM_COLS data bytes to a byte writer
module led_frame_refresh #(
  parameter int NUM_COLS    = 16,
  parameter int CLK_HZ      = 12_000_000,
  parameter int REFRESH_DIV = 12_000_000,
  parameter int PAUSE_CYC   = 12_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] brightness,
  input  logic       disp_on,
  input  logic       update,
  input  logic       i_busy,
  output logic       o_valid,
  output logic [7:0] o_pos,
  output logic [7:0] o_value,
  output logic       o_active,
  output logic       o_frame_done
);
  typedef enum logic [2:0] {IDLE, CMD, PAUSE, DATA, DONE} state_t;

  if (NUM_COLS < 1 || NUM_COLS > 16 || REFRESH_DIV < 2 || CLK_HZ < 1) begin : g_bad_params
    $error("led_frame_refresh: parameter out of range");
  end

  state_t      state;
  logic [7:0]  back  [16];
  logic [7:0]  front [16];
  logic [31:0] timer;
  logic [31:0] pause_cnt;
  logic [3:0]  col;
  logic        pending;
  logic        tick;
  logic        start;
  logic        can_issue;

  assign tick      = timer == REFRESH_DIV - 1;
  assign start     = state == IDLE && pending;
  assign can_issue = !i_busy && !o_valid;
  assign o_active  = state != IDLE;

  // refresh timer and request latch run regardless of frame state; a request coinciding with start queues one more frame
  always_ff @(posedge CLK)
    if (!RST_N) begin
      timer   <= '0;
      pending <= 1'b0;
    end else begin
      timer   <= tick ? '0 : timer + 1;
      pending <= tick || update || (pending && !start);
    end

  // back buffer takes host writes; out-of-range columns are dropped
  always_ff @(posedge CLK)
    if (!RST_N) for (int i = 0; i < 16; i++) back[i] <= '0;
    else if (wr_en && 32'(wr_addr) < NUM_COLS) back[wr_addr] <= wr_data;

  // frame sequencer: snapshot, command byte, pause, data bytes, done pulse
  always_ff @(posedge CLK)
    if (!RST_N) begin
      state        <= IDLE;
      col          <= '0;
      pause_cnt    <= '0;
      o_valid      <= 1'b0;
      o_pos        <= '0;
      o_value      <= '0;
      o_frame_done <= 1'b0;
      for (int i = 0; i < 16; i++) front[i] <= '0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: if (pending) begin
          front <= back;
          col   <= '0;
          state <= CMD;
        end
        CMD: if (can_issue) begin
          o_valid   <= 1'b1;
          o_pos     <= 8'hFF;
          o_value   <= {4'b1000, disp_on, brightness};
          pause_cnt <= '0;
          state     <= PAUSE;
        end
        PAUSE: if (pause_cnt + 1 >= PAUSE_CYC) begin
          col   <= '0;
          state <= DATA;
        end else pause_cnt <= pause_cnt + 1;
        DATA: if (can_issue) begin
          o_valid <= 1'b1;
          o_pos   <= 8'hC0 + 8'(col);
          o_value <= front[col];
          if (32'(col) == NUM_COLS - 1) state <= DONE;
          else col <= col + 1;
        end
        DONE: begin
          o_frame_done <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/led_frame_refresh.md
LED_FRAME_REFRESH -- requirements
Module: led_frame_refresh

Interface
REQ-001 Parameter NUM_COLS, default 16, range 1..16: number of display columns (bytes) sent per frame.
REQ-002 Parameter CLK_HZ, default 12_000_000: input clock frequency.
REQ-003 Parameter REFRESH_DIV, default 12_000_000: clock cycles between periodic refresh ticks; must be >= 2.
REQ-004 Parameter PAUSE_CYC, default 12_000: idle cycles between the command byte and the first data byte.
REQ-005 CLK  in  1  system clock; the single clock for all logic.
REQ-006 RST_N  in  1  reset, synchronous, active-low.
REQ-007 wr_en  in  1  frame-buffer write strobe.
REQ-008 wr_addr  in  4  column index for the write.
REQ-009 wr_data  in  8  column pixel byte.
REQ-010 brightness  in  3  display brightness level, 0..7.
REQ-011 disp_on  in  1  1 = display enabled, 0 = blanked.
REQ-012 update  in  1  single-cycle request for an immediate refresh.
REQ-013 i_busy  in  1  byte writer busy flag.
REQ-014 o_valid  out  1  single-cycle strobe to the byte writer.
REQ-015 o_pos  out  8  address/command byte presented to the writer.
REQ-016 o_value  out  8  data byte presented to the writer.
REQ-017 o_active  out  1  high while a frame is in progress (any state other than IDLE).
REQ-018 o_frame_done  out  1  single-cycle pulse after the last data byte of a frame is issued.

Function
REQ-019 Back buffer: NUM_COLS x 8 bits. When wr_en=1 and wr_addr<NUM_COLS, write wr_data at the next edge. Writes with wr_addr>=NUM_COLS are ignored.
REQ-020 Front buffer: copied in full from the back buffer in the cycle the FSM leaves IDLE. A write in that same cycle lands in the back buffer only; the front buffer takes the pre-write value.
REQ-021 Tick timer: counts 0..REFRESH_DIV-1, then wraps to 0. Assert tick for one cycle on the wrap.
REQ-022 pending flag: set by tick or update, cleared when the FSM leaves IDLE. If tick/update coincides with leaving IDLE, pending stays set (queues one further frame). Multiple requests collapse into one.
REQ-023 FSM states: IDLE, CMD, PAUSE, DATA, DONE.
REQ-024 IDLE: if pending=1, snapshot the buffers and go to CMD.
REQ-025 Issue rule, for CMD and DATA: o_valid asserts only in a cycle where i_busy=0 and o_valid was 0 in the previous cycle. Otherwise o_valid=0. o_valid is never high for two consecutive cycles.
REQ-026 CMD: on issue, o_pos=8'hFF and o_value = {4'b1000, disp_on, brightness}, with brightness and disp_on sampled that cycle. Clear the pause counter; go to PAUSE.
REQ-027 PAUSE: hold o_valid=0. Count PAUSE_CYC cycles, then go to DATA with col=0.
REQ-028 DATA: on issue, o_pos=8'hC0+col and o_value=front[col]. If col<NUM_COLS-1, increment col; otherwise go to DONE.
REQ-029 DONE: o_frame_done=1 for exactly one cycle, then go to IDLE.
REQ-030 o_pos/o_value hold their last issued values between strobes.
REQ-031 While o_active=1, changes to brightness/disp_on and new writes do not affect the current frame.
REQ-032 Timer and pending run continuously in every state.

Reset
REQ-033 RST_N=0 at a clock edge sets: FSM=IDLE, timer=0, pending=0, col=0, pause counter=0, both buffers all-zero, o_valid=0, o_pos=0, o_value=0, o_frame_done=0.
REQ-034 Reset mid-frame aborts the frame immediately; no further o_valid until a new request arrives after release.
REQ-035 The first periodic tick after release occurs REFRESH_DIV cycles later.

Verification
REQ-036 Write cols 0..15 = 8'h01..8'h10, pulse update, i_busy=0, PAUSE_CYC=4 -> strobes in order: (FF, 89 with brightness=1, disp_on=1), then (C0,01)..(CF,10). Strobes spaced >=2 cycles; o_frame_done pulses once.
REQ-037 Writer model raises i_busy for 20 cycles after each strobe -> next o_valid comes no earlier than the first cycle with i_busy=0; exactly 17 strobes per frame.
REQ-038 Write col 3=8'hAA in the cycle the FSM leaves IDLE -> the frame sends C3 with the old value; the next frame sends C3,AA.
REQ-039 update pulsed during DATA -> exactly one extra frame starts after DONE; a second update in the same frame adds nothing.
REQ-040 NUM_COLS=8, wr_addr=12 write, disp_on=0 -> command value 8'h80|brightness; positions C0..C7 only; col 12 write has no effect.
REQ-041 RST_N low for 1 cycle during PAUSE -> o_active=0 next cycle; o_valid stays 0 until the next tick or update.
